uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8x-oversampling UART receiver.
- Sits directly downstream of baudgen and consumes its bclkx8 output.
- Converts the asynchronous serial line rxd into parallel bytes for the host.
- Exposes a receive-data-register-full flag with read handshake, plus framing and overrun error flags.

Parameters:
DATA_BITS, 8, data bits per frame (LSB first), legal 5..8
OVERSAMPLE, 8, bclkx8 ticks per bit period; must be even

Ports:
clk      input   1          system clock
rstb     input   1          reset, asynchronous, active-low
bclkx8   input   1          8x baud signal from baudgen, a level in the clk domain; each rising edge = one tick
rxd      input   1          serial line, idle high, asynchronous to clk
rd       input   1          host read strobe, 1 clk; clears rdrf/ferr/oerr
rx_data  output  DATA_BITS  last received byte
rdrf     output  1          receive data register full
ferr     output  1          framing error on the byte in rx_data
oerr     output  1          overrun: a byte was overwritten before being read
busy     output  1          frame reception in progress (state != IDLE)

Behaviour:
- Reset (rstb low, async): rx_data=0, rdrf=0, ferr=0, oerr=0, busy=0, state=IDLE.
  - Synchronizer flops reset to 1; bclkx8 delay flop resets to 0; all counters reset to 0.
  - Reset mid-frame abandons the frame with no flags set.
- rxd passes through a 2-flop synchronizer to give rxs.
- tick = bclkx8 & ~bclkx8_d, a one-clk pulse per bclkx8 rising edge.
- All FSM activity advances only on tick; between ticks the state holds.
- tcnt: 3-bit tick counter. bcnt: bit counter.
- IDLE:
  - tick & rxs==0 -> START, tcnt=0.
- START:
  - tick: tcnt++.
  - At tcnt==OVERSAMPLE/2-1 (mid start bit): rxs==0 -> DATA with tcnt=0, bcnt=0; rxs==1 -> IDLE (glitch reject, no flags).
- DATA:
  - tick: tcnt++.
  - At tcnt==OVERSAMPLE-1: shift rxs into the MSB of the shift register (right shift), bcnt++, tcnt=0.
  - After sample DATA_BITS-1 -> STOP.
- STOP:
  - At tcnt==OVERSAMPLE-1 (mid stop bit), in the same clk: rx_data<=shift register, rdrf<=1, ferr<=~rxs.
  - Same clk: oerr<=1 if rdrf==1 and rd==0, else oerr keeps its value.
  - rxs==1 -> IDLE; rxs==0 -> BREAK.
- BREAK:
  - Wait for rxs==1 (tick not required) -> IDLE.
  - Prevents a low stop bit or line break being taken as a new start bit.
- rd:
  - At the next clk edge, clears rdrf, ferr, oerr.
  - rd while rdrf==0 has no effect.
- Simultaneous rd and frame completion in the same clk:
  - Completion wins: rdrf=1, ferr reflects the new frame, oerr=0 (old byte counted as read).
- Latency: rdrf rises 1 clk after the tick sampling the stop bit, i.e. about 9.5 bit periods after the falling edge of the start bit.
- rxd changes are seen by the FSM 2-3 clks late (synchronizer); this is tolerated by mid-bit sampling.
- rx_data holds until the next frame completes, independent of rd.
- busy is combinational from state and is 1 in START/DATA/STOP/BREAK.

Decomposition:
- Package uart_pkg holds:
  - State encoding: IDLE=0, START=1, DATA=2, STOP=3, BREAK=4 (3 bits).
  - Default DATA_BITS and OVERSAMPLE constants, shared with the future uart_tx.
- One sub-module, uart_sync_edge, contains:
  - The 2-flop rxd synchronizer.
  - The bclkx8 rising-edge detector.
  - Outputs: rxs, tick.
- FSM, counters and flags stay in uart_rx.

Test Plan:
- Bench drives bclkx8 high for 1 clk every 4 clks, so 1 bit = 32 clks. Send 0xA5 with a valid stop bit -> rdrf=1, rx_data=0xA5, ferr=0, oerr=0; busy low after STOP.
- Start glitch: rxd low for 8 clks, then high -> FSM returns to IDLE; rdrf, ferr, busy all 0 after about 20 clks.
- Framing error: send 0x3C with stop bit low, then rxd high after 2 bit times -> rx_data=0x3C, rdrf=1, ferr=1. FSM waits in BREAK, then accepts a following 0x55 correctly.
- Overrun: send 0x11 then 0x22 with no rd -> rx_data=0x22, rdrf=1, oerr=1. Pulse rd -> rdrf=0, oerr=0.
- rd asserted in the same clk as the 0x77 stop-bit sample, with rdrf already 1 -> rdrf=1, oerr=0, rx_data=0x77.
- rstb pulsed low mid-DATA while receiving 0xF0 -> all outputs 0 immediately (async). A subsequent 0x81 frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions: default frame geometry and the receiver FSM
// state encoding. Also intended for use by the companion transmitter.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

  // Default frame geometry: 8 data bits, 8 bclkx8 ticks per bit period.
  localparam int DATA_BITS_DEF  = 8;
  localparam int OVERSAMPLE_DEF = 8;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

endpackage

// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
// Host-side bus of the UART receiver.
//   rd      : host read strobe (1 clk), clears rdrf/ferr/oerr
//   rx_data : last received byte
//   rdrf    : receive data register full
//   ferr    : framing error on the byte in rx_data
//   oerr    : a byte was overwritten before being read
//   busy    : frame reception in progress
// Modports: master = host side, slave = receiver side.
// -----------------------------------------------------------------------------
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF
) ();

  logic                 rd;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rdrf;
  logic                 ferr;
  logic                 oerr;
  logic                 busy;

  modport master (
    output rd,
    input  rx_data,
    input  rdrf,
    input  ferr,
    input  oerr,
    input  busy
  );

  modport slave (
    input  rd,
    output rx_data,
    output rdrf,
    output ferr,
    output oerr,
    output busy
  );

endinterface

// File: rtl/uart_sync_edge.sv
// -----------------------------------------------------------------------------
// uart_sync_edge
// Front end of the receiver: brings the asynchronous serial line into the
// clk domain and turns the bclkx8 level into a one-clk tick per rising edge.
//   clk    : system clock
//   rstb   : asynchronous active-low reset
//   bclkx8 : 8x baud level (already in the clk domain)
//   rxd    : raw serial line, idle high
//   rxs    : synchronized rxd (2-flop)
//   tick   : one-clk pulse on each bclkx8 rising edge
// -----------------------------------------------------------------------------
module uart_sync_edge (
  input  logic clk,
  input  logic rstb,
  input  logic bclkx8,
  input  logic rxd,
  output logic rxs,
  output logic tick
);

  logic [1:0] sync_q, sync_d;
  logic       bclkx8_dly_q, bclkx8_dly_d;

  always_comb begin
    sync_d       = {sync_q[0], rxd};
    bclkx8_dly_d = bclkx8;
  end

  // Synchronizer resets to the idle (high) line level so that leaving reset
  // never looks like a start bit.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sync_q       <= 2'b11;
      bclkx8_dly_q <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      bclkx8_dly_q <= bclkx8_dly_d;
    end
  end

  assign rxs  = sync_q[1];
  assign tick = bclkx8 & ~bclkx8_dly_q;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// Oversampling UART receiver. Detects the start bit, samples each data bit
// (LSB first) and the stop bit at mid-bit, and presents the byte to the host
// with full/framing/overrun flags.
//   clk    : system clock
//   rstb   : asynchronous active-low reset
//   bclkx8 : oversampling baud level from baudgen
//   rxd    : serial line, idle high, asynchronous to clk
//   bus    : host interface (rd in; rx_data, rdrf, ferr, oerr, busy out)
// -----------------------------------------------------------------------------
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic      clk,
  input  logic      rstb,
  input  logic      bclkx8,
  input  logic      rxd,
  uart_rx_if.slave  bus
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  logic rxs;
  logic tick;

  state_t               state_q, state_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 rdrf_q, rdrf_d;
  logic                 ferr_q, ferr_d;
  logic                 oerr_q, oerr_d;

  uart_sync_edge u_sync_edge (
    .clk    (clk),
    .rstb   (rstb),
    .bclkx8 (bclkx8),
    .rxd    (rxd),
    .rxs    (rxs),
    .tick   (tick)
  );

  always_comb begin
    state_d = state_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    rdrf_d  = rdrf_q;
    ferr_d  = ferr_q;
    oerr_d  = oerr_q;

    // Host read clears the flags; a frame completing in the same clk
    // overrides below, with the old byte counted as read.
    if (bus.rd && rdrf_q) begin
      rdrf_d = 1'b0;
      ferr_d = 1'b0;
      oerr_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (tick && !rxs) begin
          state_d = ST_START;
          tcnt_d  = '0;
        end
      end
      ST_START: begin
        if (tick) begin
          if (tcnt_q == T_HALF) begin
            // Mid start bit: a line already back high was only a glitch.
            state_d = rxs ? ST_IDLE : ST_DATA;
            tcnt_d  = '0;
            bcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (tcnt_q == T_FULL) begin
            shift_d = {rxs, shift_q[DATA_BITS-1:1]};
            tcnt_d  = '0;
            bcnt_d  = bcnt_q + BW'(1);
            if (bcnt_q == B_LAST) begin
              state_d = ST_STOP;
            end
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (tcnt_q == T_FULL) begin
            data_d = shift_q;
            rdrf_d = 1'b1;
            ferr_d = ~rxs;
            if (rdrf_q && !bus.rd) begin
              oerr_d = 1'b1;
            end
            tcnt_d  = '0;
            // A low stop bit means the line may still be held low; wait
            // for it to return high before hunting for a new start bit.
            state_d = rxs ? ST_IDLE : ST_BREAK;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      ST_BREAK: begin
        if (rxs) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= ST_IDLE;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
      rdrf_q  <= 1'b0;
      ferr_q  <= 1'b0;
      oerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      rdrf_q  <= rdrf_d;
      ferr_q  <= ferr_d;
      oerr_q  <= oerr_d;
    end
  end

  assign bus.rx_data = data_q;
  assign bus.rdrf    = rdrf_q;
  assign bus.ferr    = ferr_q;
  assign bus.oerr    = oerr_q;
  assign bus.busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx. bclkx8 is high for one clk in every four,
// so one bit period is 32 clks. Expected host-side state comes from a
// frame-level model of the receiver's visible behaviour.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int BIT_CLKS = 32;
  // Clks from the start-bit falling edge (aligned to a bclkx8 rise) to the
  // clk in which the stop bit is sampled: 1 tick to see the synchronized low,
  // then 4 + 8*8 + 8 ticks of 4 clks each.
  localparam int STOP_SAMPLE_CLKS = 4 + (4 + 8 * 8 + 8) * 4;

  logic clk;
  logic rstb;
  logic bclkx8;
  logic rxd;

  uart_rx_if #(.DATA_BITS(8)) bus ();

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(8)) dut (
    .clk    (clk),
    .rstb   (rstb),
    .bclkx8 (bclkx8),
    .rxd    (rxd),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Frame-level model of the host-visible registers.
  logic [7:0] m_data;
  logic       m_rdrf, m_ferr, m_oerr;

  logic [11:0] obs, expv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned phase = 0;
  initial bclkx8 = 1'b0;
  always @(negedge clk) begin
    phase  = (phase + 1) % 4;
    bclkx8 = (phase == 0);
  end

  function automatic logic [11:0] status();
    return {bus.rx_data, bus.rdrf, bus.ferr, bus.oerr, bus.busy};
  endfunction

  function automatic logic [11:0] model_status(input logic busy);
    return {m_data, m_rdrf, m_ferr, m_oerr, busy};
  endfunction

  task automatic model_reset();
    m_data = 8'h00; m_rdrf = 1'b0; m_ferr = 1'b0; m_oerr = 1'b0;
  endtask

  // A frame completes: byte replaces the old one; overrun only if the old
  // byte was still unread and not being read in that same clk.
  task automatic model_frame(input logic [7:0] data, input bit stop_ok, input bit rd_same);
    if (rd_same) m_oerr = 1'b0;
    else if (m_rdrf) m_oerr = 1'b1;
    m_data = data;
    m_rdrf = 1'b1;
    m_ferr = !stop_ok;
  endtask

  task automatic host_read();
    @(negedge clk);
    bus.rd = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0;
    if (m_rdrf) begin
      m_rdrf = 1'b0; m_ferr = 1'b0; m_oerr = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input bit stop_ok);
    @(posedge bclkx8);
    rxd = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    rxd = stop_ok;
    repeat (BIT_CLKS) @(negedge clk);
    if (!stop_ok) begin
      repeat (BIT_CLKS) @(negedge clk);
      rxd = 1'b1;
    end
    repeat (16) @(negedge clk);
    $display("frame data=%h stop=%0d -> rx_data=%h rdrf=%0d ferr=%0d oerr=%0d busy=%0d",
             data, stop_ok, bus.rx_data, bus.rdrf, bus.ferr, bus.oerr, bus.busy);
  endtask

  task automatic test_reset();
    rstb = 1'b0; rxd = 1'b1; bus.rd = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    obs = status(); expv = 12'h000; checks++;
    if (obs !== expv) begin
      failures++; $display("FAIL reset_hold: got %h expected %h", obs, expv);
    end
    rstb = 1'b1;
    repeat (4) @(negedge clk);
    obs = status(); expv = model_status(1'b0); checks++;
    if (obs !== expv) begin
      failures++; $display("FAIL reset_release: got %h expected %h", obs, expv);
    end
  endtask

  task automatic test_basic();
    send_frame(8'hA5, 1'b1);
    model_frame(8'hA5, 1'b1, 1'b0);
    obs = status(); expv = model_status(1'b0); checks++;
    if (obs !== expv) begin
      failures++; $display("FAIL basic_a5: got %h expected %h", obs, expv);
    end
    host_read();
    obs = status(); expv = model_status(1'b0); checks++;
    if (obs !== expv) begin
      failures++; $display("FAIL basic_read: got %h expected %h", obs, expv);
    end
  endtask

  task automatic test_glitch();
    @(posedge bclkx8);
    rxd = 1'b0;
    repeat (8) @(negedge clk);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++; $display("FAIL glitch_busy_start: got %b expected 1", bus.busy);
    end
    repeat (14) @(negedge clk);
    obs = status(); expv = model_status(1'b0); checks++;
    if (obs !== expv) begin
      failures++; $display("FAIL glitch_reject: got %h expected %h", obs, expv);
    end
    $display("glitch rdrf=%0d ferr=%0d busy=%0d", bus.rdrf, bus.ferr, bus.busy);
  endtask

  task automatic test_framing();
    fork
      send_frame(8'h3C, 1'b0);
      begin
        @(posedge bclkx8);
        repeat (STOP_SAMPLE_CLKS + 22) @(negedge clk);
        obs = status(); expv = {8'h3C, 1'b1, 1'b1, 1'b0, 1'b1}; checks++;
        if (obs !== expv) begin
          failures++; $display("FAIL framing_break: got %h expected %h", obs, expv);
        end
      end
    join
    model_frame(8'h3C, 1'b0, 1'b0);
    obs = status(); expv = model_status(1'b0); checks++;
    if (obs !== expv) begin
      failures++; $display("FAIL framing_3c: got %h expected %h", obs, expv);
    end
    host_read();
    send_frame(8'h55, 1'b1);
    model_frame(8'h55, 1'b1, 1'b0);
    obs = status(); expv = model_status(1'b0); checks++;
    if (obs !== expv) begin
      failures++; $display("FAIL framing_then_55: got %h expected %h", obs, expv);
    end
    host_read();
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1);
    model_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1);
    model_frame(8'h22, 1'b1, 1'b0);
    obs = status(); expv = model_status(1'b0); checks++;
    if (obs !== expv) begin
      failures++; $display("FAIL overrun_22: got %h expected %h", obs, expv);
    end
    host_read();
    obs = status(); expv = model_status(1'b0); checks++;
    if (obs !== expv) begin
      failures++; $display("FAIL overrun_read: got %h expected %h", obs, expv);
    end
  endtask

  task automatic test_rd_collision();
    send_frame(8'h33, 1'b1);
    model_frame(8'h33, 1'b1, 1'b0);
    fork
      send_frame(8'h77, 1'b1);
      begin
        @(posedge bclkx8);
        repeat (STOP_SAMPLE_CLKS) @(negedge clk);
        bus.rd = 1'b1;
        @(negedge clk);
        bus.rd = 1'b0;
      end
    join
    model_frame(8'h77, 1'b1, 1'b1);
    obs = status(); expv = model_status(1'b0); checks++;
    if (obs !== expv) begin
      failures++; $display("FAIL rd_collision_77: got %h expected %h", obs, expv);
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] f0;
    send_frame(8'h5A, 1'b1);
    model_frame(8'h5A, 1'b1, 1'b0);
    f0 = 8'hF0;
    @(posedge bclkx8);
    rxd = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = f0[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    #3;
    rstb = 1'b0;
    rxd  = 1'b1;
    model_reset();
    #1;
    obs = status(); expv = 12'h000; checks++;
    if (obs !== expv) begin
      failures++; $display("FAIL reset_async_mid: got %h expected %h", obs, expv);
    end
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    repeat (8) @(negedge clk);
    obs = status(); expv = model_status(1'b0); checks++;
    if (obs !== expv) begin
      failures++; $display("FAIL reset_mid_release: got %h expected %h", obs, expv);
    end
    send_frame(8'h81, 1'b1);
    model_frame(8'h81, 1'b1, 1'b0);
    obs = status(); expv = model_status(1'b0); checks++;
    if (obs !== expv) begin
      failures++; $display("FAIL reset_then_81: got %h expected %h", obs, expv);
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    bit         stop_ok;
    for (int n = 0; n < 8; n++) begin
      d       = 8'($urandom_range(0, 255));
      stop_ok = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) host_read();
      send_frame(d, stop_ok);
      model_frame(d, stop_ok, 1'b0);
      obs = status(); expv = model_status(1'b0); checks++;
      if (obs !== expv) begin
        failures++; $display("FAIL random_%0d: got %h expected %h", n, obs, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_overrun();
    test_rd_collision();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
